vram_arbiter: RTL and testbench

Shares the single-port synchronous video RAM between the video scan-out fetcher and the Z8 CPU bus inside the SoC. Video fetches have fixed deadlines and always win the port. CPU reads and writes are granted in every remaining slot through a request/acknowledge handshake. The block drives the RAM port directly and returns read data to whichever requester owns the completing access.

---
 rtl/vram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port sync video RAM between the
// video fetcher (fixed priority) and the Z8 CPU request/ack port.
//
// Parameters: ADDR_W (word address width), DATA_W (data width).
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   vidReq/vidAddr           one-cycle video fetch request
//   vidData/vidValid         fetched byte, one-cycle valid pulse
//   cpuReq/cpuWe/cpuAddr/    CPU request, held until cpuAck
//   cpuWdata
//   cpuRdata/cpuAck          read data, one-cycle completion pulse
//   ramEn/ramWe/ramAddr/     registered RAM port
//   ramWdata/ramRdata        (read data one cycle after RAM sample)
// Option: define VRAM_ARB_POSTED_WRITE_EN for a one-entry CPU
//   write buffer (write acked at once, drained on a free slot).
module vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vidReq,
  input  logic [ADDR_W-1:0] vidAddr,
  output logic [DATA_W-1:0] vidData,
  output logic              vidValid,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWdata,
  output logic [DATA_W-1:0] cpuRdata,
  output logic              cpuAck,
  output logic              ramEn,
  output logic              ramWe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramWdata,
  input  logic [DATA_W-1:0] ramRdata
);

  typedef enum logic [1:0] {
    TAG_NONE, TAG_VID, TAG_RD, TAG_WR
  } tag_e;

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_BUSY, S_ACK
  } state_e;

  state_e state, nextState;
  tag_e   tag0, tag1, issueTag;

  logic              issueEn;
  logic              issueWe;
  logic [ADDR_W-1:0] issueAddr;
  logic [DATA_W-1:0] issueWdata;
  logic              cpuWants;
  logic              canIssue;
  logic              wbValid;

`ifdef VRAM_ARB_POSTED_WRITE_EN
  logic              canPost;
  logic              postLoad;
  logic [ADDR_W-1:0] wbAddr;
  logic [DATA_W-1:0] wbData;

  assign canPost = cpuWe & ~wbValid;
`else
  assign wbValid = 1'b0;
`endif

  // A CPU access needs the slot free of video and of a pending drain.
  assign canIssue = ~vidReq & ~wbValid;
  assign cpuWants = cpuReq | (state == S_WAIT);
  assign cpuAck   = (state == S_ACK);

  always_comb begin
    nextState  = state;
    issueEn    = 1'b0;
    issueWe    = 1'b0;
    issueTag   = TAG_NONE;
    issueAddr  = ramAddr;
    issueWdata = ramWdata;
`ifdef VRAM_ARB_POSTED_WRITE_EN
    postLoad   = 1'b0;
`endif
    if (vidReq) begin
      issueEn   = 1'b1;
      issueTag  = TAG_VID;
      issueAddr = vidAddr;
    end
`ifdef VRAM_ARB_POSTED_WRITE_EN
    else if (wbValid) begin
      issueEn    = 1'b1;
      issueWe    = 1'b1;
      issueTag   = TAG_WR;
      issueAddr  = wbAddr;
      issueWdata = wbData;
    end
`endif
    unique case (state)
      S_IDLE, S_WAIT: begin
        if (cpuWants) begin
`ifdef VRAM_ARB_POSTED_WRITE_EN
          if (canPost) begin
            postLoad  = 1'b1;
            nextState = S_ACK;
          end else
`endif
          if (canIssue) begin
            issueEn    = 1'b1;
            issueWe    = cpuWe;
            issueTag   = cpuWe ? TAG_WR : TAG_RD;
            issueAddr  = cpuAddr;
            issueWdata = cpuWdata;
            nextState  = S_BUSY;
          end else begin
            nextState = S_WAIT;
          end
        end
      end
      // Only one CPU access is ever in flight, so the tag alone
      // tells when it completes.
      S_BUSY: begin
        if (tag1 == TAG_RD || tag0 == TAG_WR)
          nextState = S_ACK;
      end
      S_ACK:   nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag0     <= TAG_NONE;
      tag1     <= TAG_NONE;
      ramEn    <= 1'b0;
      ramWe    <= 1'b0;
      ramAddr  <= '0;
      ramWdata <= '0;
      vidValid <= 1'b0;
      vidData  <= '0;
      cpuRdata <= '0;
    end else begin
      tag0     <= issueTag;
      tag1     <= tag0;
      ramEn    <= issueEn;
      ramWe    <= issueWe;
      ramAddr  <= issueAddr;
      ramWdata <= issueWdata;
      vidValid <= (tag1 == TAG_VID);
      if (tag1 == TAG_VID) vidData  <= ramRdata;
      if (tag1 == TAG_RD)  cpuRdata <= ramRdata;
    end
  end

`ifdef VRAM_ARB_POSTED_WRITE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wbValid <= 1'b0;
      wbAddr  <= '0;
      wbData  <= '0;
    end else if (postLoad) begin
      wbValid <= 1'b1;
      wbAddr  <= cpuAddr;
      wbData  <= cpuWdata;
    end else if (wbValid && !vidReq) begin
      wbValid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed cycle table, posted-write sequence and
// randomized traffic checked against a transaction-level model.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vidReq;
  logic [12:0] vidAddr;
  logic [7:0]  vidData;
  logic        vidValid;
  logic        cpuReq;
  logic        cpuWe;
  logic [12:0] cpuAddr;
  logic [7:0]  cpuWdata;
  logic [7:0]  cpuRdata;
  logic        cpuAck;
  logic        ramEn;
  logic        ramWe;
  logic [12:0] ramAddr;
  logic [7:0]  ramWdata;
  logic [7:0]  ramRdata;

  int nCmp = 0;
  int nBad = 0;

`ifdef VRAM_ARB_POSTED_WRITE_EN
  localparam int RD_BOUND = 5;
`else
  localparam int RD_BOUND = 3;
`endif
  localparam int WR_BOUND = 2;

  vram_arbiter dut (
    .clk(clk), .reset(reset),
    .vidReq(vidReq), .vidAddr(vidAddr),
    .vidData(vidData), .vidValid(vidValid),
    .cpuReq(cpuReq), .cpuWe(cpuWe),
    .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
    .cpuRdata(cpuRdata), .cpuAck(cpuAck),
    .ramEn(ramEn), .ramWe(ramWe),
    .ramAddr(ramAddr), .ramWdata(ramWdata),
    .ramRdata(ramRdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM.
  logic [7:0] mem [0:8191];
  logic [7:0] shadow [0:8191];

  always @(posedge clk) begin
    if (ramEn) begin
      if (ramWe) mem[ramAddr] = ramWdata;
      else       ramRdata <= mem[ramAddr];
    end
  end

  function automatic logic [7:0] f(input logic [12:0] a);
    return 8'((int'(a) * 37 + 11) & 255);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkLe(input string nm, input int act, input int lim);
    nCmp++;
    if (act > lim) begin
      nBad++;
      $display("FAIL %s: got %0d expected <= %0d", nm, act, lim);
    end
  endtask

  typedef struct {
    logic        rst, vReq;
    logic [12:0] vAddr;
    logic        cReq, cWe;
    logic [12:0] cAddr;
    logic [7:0]  cWd;
    logic        eEn, eWe;
    logic [12:0] eAddr;
    logic [7:0]  eWd;
    logic        eVv;
    logic [7:0]  eVd;
    logic        eAck;
    logic [7:0]  eRd;
  } vec_t;

  vec_t vec[$];

  task automatic row(input bit rst, vReq, input int vAddr,
                     input bit cReq, cWe, input int cAddr, cWd,
                     input bit eEn, eWe, input int eAddr, eWd,
                     input bit eVv, input int eVd,
                     input bit eAck, input int eRd);
    vec_t v;
    v.rst = rst;   v.vReq = vReq; v.vAddr = 13'(vAddr);
    v.cReq = cReq; v.cWe = cWe;   v.cAddr = 13'(cAddr);
    v.cWd = 8'(cWd);
    v.eEn = eEn;   v.eWe = eWe;   v.eAddr = 13'(eAddr);
    v.eWd = 8'(eWd);
    v.eVv = eVv;   v.eVd = 8'(eVd);
    v.eAck = eAck; v.eRd = 8'(eRd);
    vec.push_back(v);
  endtask

  task automatic runTable;
    vec_t v;
    string p;
    // rst vR vA  cR cW cA cD  eEn eWe eA eD  eVv eVd eAck eRd
    row(1,0,0,     0,0,0,0,        0,0,0,0,          0,0,0,0);
    row(0,0,0,     0,0,0,0,        0,0,0,0,          0,0,0,0);
    row(0,1,'h100, 0,0,0,0,        1,0,'h100,0,      0,0,0,0);
    row(0,0,0,     0,0,0,0,        0,0,0,0,          0,0,0,0);
    row(0,0,0,     0,0,0,0,        0,0,0,0,          1,'h5A,0,0);
    row(0,0,0,     0,0,0,0,        0,0,0,0,          0,'h5A,0,0);
    row(0,0,0,     1,1,'h200,'h3C, 1,1,'h200,'h3C,   0,'h5A,0,0);
    row(0,0,0,     1,1,'h200,'h3C, 0,0,0,0,          0,'h5A,1,0);
    row(0,0,0,     0,0,0,0,        0,0,0,0,          0,'h5A,0,0);
    row(0,0,0,     1,0,'h200,0,    1,0,'h200,0,      0,'h5A,0,0);
    row(0,0,0,     1,0,'h200,0,    0,0,0,0,          0,'h5A,0,0);
    row(0,0,0,     1,0,'h200,0,    0,0,0,0,          0,'h5A,1,'h3C);
    row(0,0,0,     0,0,0,0,        0,0,0,0,          0,'h5A,0,'h3C);
    row(0,1,'h020, 1,0,'h010,0,    1,0,'h020,0,      0,'h5A,0,'h3C);
    row(0,0,0,     1,0,'h010,0,    1,0,'h010,0,      0,'h5A,0,'h3C);
    row(0,0,0,     1,0,'h010,0,    0,0,0,0,          1,'h22,0,'h3C);
    row(0,0,0,     1,0,'h010,0,    0,0,0,0,          0,'h22,1,'h11);
    row(0,0,0,     0,0,0,0,        0,0,0,0,          0,'h22,0,'h11);
    row(0,1,'h100, 0,0,0,0,        1,0,'h100,0,      0,'h22,0,'h11);
    row(0,0,0,     1,1,'h300,'h77, 1,1,'h300,'h77,   0,'h22,0,'h11);
    row(0,0,0,     1,1,'h300,'h77, 0,0,0,0,          1,'h5A,1,'h11);
    row(0,0,0,     0,0,0,0,        0,0,0,0,          0,'h5A,0,'h11);
    row(0,0,0,     1,0,'h300,0,    1,0,'h300,0,      0,'h5A,0,'h11);
    row(0,0,0,     1,0,'h300,0,    0,0,0,0,          0,'h5A,0,'h11);
    row(0,0,0,     1,0,'h300,0,    0,0,0,0,          0,'h5A,1,'h77);
    row(0,0,0,     0,0,0,0,        0,0,0,0,          0,'h5A,0,'h77);
    row(0,0,0,     1,1,'h301,'h99, 1,1,'h301,'h99,   0,'h5A,0,'h77);
    row(0,0,0,     1,1,'h301,'h99, 0,0,0,0,          0,'h5A,1,'h77);
    row(0,0,0,     1,1,'h301,'h99, 0,0,0,0,          0,'h5A,0,'h77);
    row(0,0,0,     1,1,'h301,'h99, 1,1,'h301,'h99,   0,'h5A,0,'h77);
    row(0,0,0,     1,1,'h301,'h99, 0,0,0,0,          0,'h5A,1,'h77);
    row(0,0,0,     0,0,0,0,        0,0,0,0,          0,'h5A,0,'h77);
    row(0,0,0,     1,0,'h100,0,    1,0,'h100,0,      0,'h5A,0,'h77);
    row(1,0,0,     1,0,'h100,0,    0,0,0,0,          0,0,0,0);
    row(0,0,0,     0,0,0,0,        0,0,0,0,          0,0,0,0);
    row(0,0,0,     0,0,0,0,        0,0,0,0,          0,0,0,0);
    for (int i = 0; i < vec.size(); i++) begin
      v = vec[i];
      reset = v.rst;  vidReq = v.vReq; vidAddr = v.vAddr;
      cpuReq = v.cReq; cpuWe = v.cWe;  cpuAddr = v.cAddr;
      cpuWdata = v.cWd;
      tick;
      p = $sformatf("row%0d", i);
      chk({p, " ramEn"}, 32'(ramEn), 32'(v.eEn));
      chk({p, " ramWe"}, 32'(ramWe), 32'(v.eWe));
      if (v.eEn || v.rst)
        chk({p, " ramAddr"}, 32'(ramAddr), 32'(v.eAddr));
      if ((v.eEn && v.eWe) || v.rst)
        chk({p, " ramWdata"}, 32'(ramWdata), 32'(v.eWd));
      chk({p, " vidValid"}, 32'(vidValid), 32'(v.eVv));
      chk({p, " vidData"}, 32'(vidData), 32'(v.eVd));
      chk({p, " cpuAck"}, 32'(cpuAck), 32'(v.eAck));
      chk({p, " cpuRdata"}, 32'(cpuRdata), 32'(v.eRd));
    end
  endtask

  // Transaction-level traffic: video returns exactly 2 edges after
  // the request, CPU ops complete in order within a latency bound
  // and read back the last value the CPU wrote.
  task automatic traffic(input int nCyc, input bit fixedVid,
                         input int maxCpu, input bit readsOnly);
    int          lastVid = -10;
    int          started = 0;
    int          done = 0;
    int          start = 0;
    bit          pend = 0;
    bit          justAcked = 0;
    bit          cw = 0;
    bit          expV;
    logic [12:0] ca = '0;
    logic [7:0]  cd = '0;
    int          vq[$];
    logic [7:0]  vdq[$];
    vidReq = 0; cpuReq = 0; cpuWe = 0;
    for (int cyc = 0; cyc < nCyc + 30; cyc++) begin
      vidReq = 0;
      if (cyc < nCyc && cyc - lastVid >= 2 &&
          (fixedVid || $urandom_range(0, 1) == 1)) begin
        vidReq  = 1;
        vidAddr = 13'h1000 | 13'($urandom_range(0, 4095));
        lastVid = cyc;
        vq.push_back(cyc + 2);
        vdq.push_back(f(vidAddr));
      end
      if (!pend && !justAcked && cyc < nCyc && started < maxCpu &&
          (fixedVid || $urandom_range(0, 2) != 0)) begin
        pend = 1; start = cyc; started++;
        cw = readsOnly ? 1'b0 : 1'($urandom_range(0, 1));
        ca = 13'h0400 | 13'($urandom_range(0, 1023));
        cd = 8'($urandom);
        cpuReq = 1; cpuWe = cw; cpuAddr = ca; cpuWdata = cd;
      end
      justAcked = 0;
      tick;
      expV = (vq.size() > 0 && vq[0] == cyc);
      if (expV || vidValid)
        chk("vidValid timing", 32'(vidValid), 32'(expV));
      if (expV) begin
        chk("vidData", 32'(vidData), 32'(vdq[0]));
        void'(vq.pop_front());
        void'(vdq.pop_front());
      end
      if (cpuAck) begin
        if (vidValid) chk("vid+ack only on write", 32'(cw), 32'd1);
        chk("cpuAck while pending", 32'(pend), 32'd1);
        if (pend) begin
          chkLe(cw ? "wr latency" : "rd latency", cyc - start,
                cw ? WR_BOUND : RD_BOUND);
          if (cw) shadow[ca] = cd;
          else chk("cpuRdata", 32'(cpuRdata), 32'(shadow[ca]));
          done++;
        end
        pend = 0; cpuReq = 0; justAcked = 1;
      end else if (pend && cyc - start > 12) begin
        chkLe("cpu ack timeout", cyc - start, 12);
        pend = 0; cpuReq = 0; justAcked = 1;
      end
    end
    chk("traffic cpu left pending", 32'(pend), 32'd0);
    chk("traffic video left pending", 32'(vq.size()), 32'd0);
    if (fixedVid) chk("fixed reads done", 32'(done), 32'(maxCpu));
  endtask

`ifdef VRAM_ARB_POSTED_WRITE_EN
  task automatic postedSeq;
    int n = 0;
    vidReq = 1; vidAddr = 13'h1100;
    cpuReq = 1; cpuWe = 1; cpuAddr = 13'h0500; cpuWdata = 8'hE1;
    tick;
    chk("pw ack next cycle", 32'(cpuAck), 32'd1);
    chk("pw video first", 32'(ramAddr), 32'h1100);
    chk("pw video not write", 32'(ramWe), 32'd0);
    vidReq = 0; cpuReq = 0;
    tick;
    chk("pw drain en", 32'(ramEn & ramWe), 32'd1);
    chk("pw drain addr", 32'(ramAddr), 32'h0500);
    chk("pw drain data", 32'(ramWdata), 32'hE1);
    chk("pw ack single", 32'(cpuAck), 32'd0);
    shadow[13'h0500] = 8'hE1;
    cpuReq = 1; cpuWe = 0; cpuAddr = 13'h0500;
    do begin
      tick;
      n++;
    end while (!cpuAck && n < 8);
    chk("pw readback ack", 32'(cpuAck), 32'd1);
    chk("pw readback data", 32'(cpuRdata), 32'hE1);
    cpuReq = 0;
    repeat (4) tick;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 8192; a++) begin
      mem[a]    = f(13'(a));
      shadow[a] = f(13'(a));
    end
    mem[13'h0100] = 8'h5A;
    mem[13'h0010] = 8'h11;
    mem[13'h0020] = 8'h22;
    reset = 1; vidReq = 0; vidAddr = '0;
    cpuReq = 0; cpuWe = 0; cpuAddr = '0; cpuWdata = '0;
    tick;
    tick;
    reset = 0;
    tick;
`ifdef VRAM_ARB_POSTED_WRITE_EN
    postedSeq;
`else
    runTable;
`endif
    reset = 0;
    traffic(20, 1'b1, 4, 1'b1);
    traffic(3000, 1'b0, 1 << 30, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
